data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
// - Multi-cycle load/store controller and data memory that drives DataMemOut.
// - DataMemOut is the Source2 input of the writeback select (ALU/shift vs. memory).
// - Accepts one load or store from the core at a time.
// - Stalls the core while a request is in flight.
// - Pulses completion in the cycle DataMemOut is valid.
// PARAMETERS
// - ADDR_W         8  address width; array depth = 2**ADDR_W
// - DATA_W         8  data width
// - READ_LATENCY   2  edges from accepting a load to DataMemOut update; must be >= 1
// - WRITE_LATENCY  1  edges from accepting a store to the array write; must be >= 1
// PORTS
// - CLK         in   1       single clock; all state updates on its rising edge
// - Reset       in   1       asynchronous, active-low reset
// - MemRead     in   1       load request, sampled in IDLE
// - MemWrite    in   1       store request, sampled in IDLE
// - Address     in   ADDR_W  request address, latched on accept
// - DataIn      in   DATA_W  store data, latched on accept
// - DataMemOut  out  DATA_W  load result; holds its value until the next load completes
// - MemDone     out  1       one-cycle pulse on load/store completion
// - MemStall    out  1       high while state != IDLE
// - MemErr      out  1       one-cycle pulse on an illegal request
// BEHAVIOUR
// - Reset asserted: state=IDLE, Cnt=0, DataMemOut=0, MemDone=0, MemErr=0, so MemStall=0.
//   - The array is not cleared.
//   - Reset mid-operation aborts it: no array write, no MemDone.
// - States: IDLE, READ, WRITE.
// - IDLE, MemRead=1 and MemWrite=0 at an edge:
//   - latch Address into AddrQ; Cnt <= READ_LATENCY-1; next state READ.
// - IDLE, MemWrite=1 and MemRead=0 at an edge:
//   - latch Address and DataIn; Cnt <= WRITE_LATENCY-1; next state WRITE.
// - IDLE, MemRead=1 and MemWrite=1:
//   - nothing accepted; MemErr=1 for the next cycle; state stays IDLE.
// - READ: if Cnt==0 then DataMemOut <= mem[AddrQ], MemDone <= 1, state <= IDLE; else Cnt--.
// - WRITE: if Cnt==0 then mem[AddrQ] <= DataQ, MemDone <= 1, state <= IDLE; else Cnt--.
// - Load accepted at edge t:
//   - DataMemOut is valid and MemDone=1 in the cycle after edge t+READ_LATENCY.
//   - MemStall is high in the cycles between edge t and edge t+READ_LATENCY.
// - MemDone and MemErr are registered and self-clear after one cycle.
// - Requests while not IDLE are ignored; the core must hold them, being stalled.
// - Back-to-back requests have no bubble:
//   - state is IDLE in the MemDone cycle, so a new request is accepted at the next edge.
// - Read-after-write to the same address returns the newly written data.
// - Address wrap: index is Address[ADDR_W-1:0]; no out-of-range case exists.
// - Cnt width = $clog2(max(READ_LATENCY,WRITE_LATENCY)+1).
// - Either latency < 1 is an elaboration-time $error.
// STRUCTURE
// - Package mem_pkg:
//   - typedef enum logic [1:0] {IDLE, READ, WRITE} mem_state_t;
//   - default ADDR_W/DATA_W constants.
// - Sub-module dm_array: 2**ADDR_W x DATA_W storage.
//   - synchronous write port (we, waddr, wdata); combinational read port (raddr -> rdata); no reset.
// - The FSM, counter, latches and output registers live in data_mem_ctrl.
// TESTING
// - Reset low mid-sim -> DataMemOut=0, MemDone=0, MemStall=0, MemErr=0 immediately (async).
// - Store Address=8'h10, DataIn=8'hA5 -> MemDone pulse 1 cycle after the write edge.
//   - Then load 8'h10 -> MemStall high 2 cycles, DataMemOut=8'hA5 with MemDone=1.
// - MemRead=MemWrite=1 in IDLE -> MemErr 1-cycle pulse, MemStall stays 0, array unchanged.
// - Load 8'h10 immediately followed by store 8'h10=8'h3C:
//   - first load returns 8'hA5; the store is accepted at the edge after that MemDone (no bubble).
//   - a later load returns 8'h3C.
// - Change Address/DataIn while in READ -> ignored; the result reflects the latched address.
// - Reset asserted while in READ, then released, then load 8'h10:
//   - no MemDone during reset; the array contents are retained and the load returns 8'h3C.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the load/store data memory controller.
// Holds the controller state encoding and the default parameter values.
package mem_pkg;

   typedef enum logic [1:0] {IDLE, READ, WRITE} mem_state_t;

   localparam int ADDR_W_DEF        = 8;
   localparam int DATA_W_DEF        = 8;
   localparam int READ_LATENCY_DEF  = 2;
   localparam int WRITE_LATENCY_DEF = 1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dm_array.sv
// Data storage: one synchronous write port and one combinational read port.
// The contents are never reset, so stored data survives a controller reset.
module dm_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_reg [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_reg[waddr] <= wdata;
      end
   end

   assign rdata = mem_reg[raddr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle load/store controller in front of dm_array; stalls the core while
// a request is in flight and pulses MemDone in the cycle DataMemOut is valid.
module data_mem_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int READ_LATENCY  = READ_LATENCY_DEF,
   parameter int WRITE_LATENCY = WRITE_LATENCY_DEF
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] Address,
   input  logic [DATA_W-1:0] DataIn,
   output logic [DATA_W-1:0] DataMemOut,
   output logic              MemDone,
   output logic              MemStall,
   output logic              MemErr
);

   localparam int CNT_W = $clog2(max_int(READ_LATENCY, WRITE_LATENCY) + 1);
   localparam logic [CNT_W-1:0] RD_INIT  = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_INIT  = CNT_W'(WRITE_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   generate
      if (READ_LATENCY < 1) begin : g_bad_read_latency
         $error("data_mem_ctrl: READ_LATENCY must be >= 1");
      end
      if (WRITE_LATENCY < 1) begin : g_bad_write_latency
         $error("data_mem_ctrl: WRITE_LATENCY must be >= 1");
      end
   endgenerate

   mem_state_t        state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [ADDR_W-1:0] addr_q_reg;
   logic [DATA_W-1:0] data_q_reg;
   logic [DATA_W-1:0] dout_reg;
   logic              done_reg;
   logic              err_reg;
   logic [DATA_W-1:0] rdata;
   logic              mem_we;

   // The array write fires on the same edge the WRITE state retires, so an
   // async reset that has already returned the FSM to IDLE suppresses it.
   assign mem_we = (state_reg == WRITE) && (cnt_reg == '0);

   dm_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (CLK),
      .we    (mem_we),
      .waddr (addr_q_reg),
      .wdata (data_q_reg),
      .raddr (addr_q_reg),
      .rdata (rdata)
   );

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         addr_q_reg <= '0;
         data_q_reg <= '0;
         dout_reg   <= '0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (MemRead && MemWrite) begin
                  err_reg <= 1'b1;
               end else if (MemRead) begin
                  addr_q_reg <= Address;
                  cnt_reg    <= RD_INIT;
                  state_reg  <= READ;
               end else if (MemWrite) begin
                  addr_q_reg <= Address;
                  data_q_reg <= DataIn;
                  cnt_reg    <= WR_INIT;
                  state_reg  <= WRITE;
               end
            end
            READ: begin
               if (cnt_reg == '0) begin
                  dout_reg  <= rdata;
                  done_reg  <= 1'b1;
                  state_reg <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg - CNT_ONE;
               end
            end
            WRITE: begin
               if (cnt_reg == '0) begin
                  done_reg  <= 1'b1;
                  state_reg <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg - CNT_ONE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign DataMemOut = dout_reg;
   assign MemDone    = done_reg;
   assign MemErr     = err_reg;
   assign MemStall   = (state_reg != IDLE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: stores, loads, illegal requests, back-to-back
// traffic, ignored mid-flight inputs and asynchronous reset in flight.
module tb_data_mem_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mem_read = 1'b0;
   logic       mem_write = 1'b0;
   logic [7:0] address = 8'h00;
   logic [7:0] data_in = 8'h00;
   logic [7:0] dout;
   logic       done;
   logic       stall;
   logic       err;

   int n_cmp = 0;
   int n_fail = 0;

   data_mem_ctrl #(
      .ADDR_W        (8),
      .DATA_W        (8),
      .READ_LATENCY  (2),
      .WRITE_LATENCY (1)
   ) dut (
      .CLK        (clk),
      .Reset      (rst_n),
      .MemRead    (mem_read),
      .MemWrite   (mem_write),
      .Address    (address),
      .DataIn     (data_in),
      .DataMemOut (dout),
      .MemDone    (done),
      .MemStall   (stall),
      .MemErr     (err)
   );

   always #5 clk = ~clk;

   // Issue a load at a negedge; return at the negedge where MemDone is seen.
   task automatic do_load(input logic [7:0] a, output logic [7:0] d, output int stall_cycles);
      bit found = 1'b0;
      stall_cycles = 0;
      d = 8'h00;
      mem_read = 1'b1;
      address = a;
      @(negedge clk);
      mem_read = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (done) begin
            found = 1'b1;
            d = dout;
         end else begin
            if (stall) stall_cycles++;
            @(negedge clk);
         end
      end
      if (!found) stall_cycles = -1;
      $display("load  addr=%h data=%h stall_cycles=%0d", a, d, stall_cycles);
   endtask

   task automatic do_store(input logic [7:0] a, input logic [7:0] v, output int stall_cycles);
      bit found = 1'b0;
      stall_cycles = 0;
      mem_write = 1'b1;
      address = a;
      data_in = v;
      @(negedge clk);
      mem_write = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (done) begin
            found = 1'b1;
         end else begin
            if (stall) stall_cycles++;
            @(negedge clk);
         end
      end
      if (!found) stall_cycles = -1;
      $display("store addr=%h data=%h stall_cycles=%0d", a, v, stall_cycles);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%h exp=00", dout); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset released");
   endtask

   task automatic test_store_load();
      int sc;
      logic [7:0] d;
      do_store(8'h10, 8'hA5, sc);
      n_cmp++; if (sc !== 1) begin n_fail++; $display("FAIL store_stall_cycles got=%0d exp=1", sc); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL store_done_clear got=%b exp=0", done); end
      do_load(8'h10, d, sc);
      n_cmp++; if (d !== 8'hA5) begin n_fail++; $display("FAIL load_data got=%h exp=a5", d); end
      n_cmp++; if (sc !== 2) begin n_fail++; $display("FAIL load_stall_cycles got=%0d exp=2", sc); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL load_done_clear got=%b exp=0", done); end
      n_cmp++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL load_dout_hold got=%h exp=a5", dout); end
   endtask

   task automatic test_err();
      int sc;
      logic [7:0] d;
      mem_read = 1'b1;
      mem_write = 1'b1;
      address = 8'h10;
      data_in = 8'hFF;
      @(negedge clk);
      mem_read = 1'b0;
      mem_write = 1'b0;
      $display("illegal request err=%b stall=%b", err, stall);
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_pulse got=%b exp=1", err); end
      n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL err_stall got=%b exp=0", stall); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL err_done got=%b exp=0", done); end
      @(negedge clk);
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got=%b exp=0", err); end
      do_load(8'h10, d, sc);
      n_cmp++; if (d !== 8'hA5) begin n_fail++; $display("FAIL err_array_unchanged got=%h exp=a5", d); end
   endtask

   task automatic test_back_to_back();
      int sc;
      logic [7:0] d;
      bit found = 1'b0;
      mem_read = 1'b1;
      address = 8'h10;
      @(negedge clk);
      mem_read = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (done) found = 1'b1;
         else @(negedge clk);
      end
      n_cmp++; if (!found) begin n_fail++; $display("FAIL b2b_load_done got=timeout exp=done"); end
      n_cmp++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL b2b_load_data got=%h exp=a5", dout); end
      $display("b2b load  addr=10 data=%h", dout);
      mem_write = 1'b1;
      data_in = 8'h3C;
      @(negedge clk);
      mem_write = 1'b0;
      n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_store_accept got=%b exp=1", stall); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_store_done got=%b exp=1", done); end
      $display("b2b store addr=10 data=3c done=%b", done);
      do_load(8'h10, d, sc);
      n_cmp++; if (d !== 8'h3C) begin n_fail++; $display("FAIL raw_data got=%h exp=3c", d); end
   endtask

   task automatic test_ignore_inflight();
      int sc;
      logic [7:0] d;
      do_store(8'h20, 8'h5A, sc);
      mem_read = 1'b1;
      address = 8'h10;
      @(negedge clk);
      mem_read = 1'b0;
      mem_write = 1'b1;
      address = 8'h20;
      data_in = 8'h77;
      @(negedge clk);
      mem_write = 1'b0;
      n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ignore_stall got=%b exp=1", stall); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL ignore_early_done got=%b exp=0", done); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL ignore_done got=%b exp=1", done); end
      n_cmp++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL ignore_latched_addr got=%h exp=3c", dout); end
      $display("inflight load addr=10 data=%h", dout);
      do_load(8'h20, d, sc);
      n_cmp++; if (d !== 8'h5A) begin n_fail++; $display("FAIL ignore_no_write got=%h exp=5a", d); end
   endtask

   task automatic test_reset_inflight();
      int sc;
      logic [7:0] d;
      mem_read = 1'b1;
      address = 8'h10;
      @(negedge clk);
      mem_read = 1'b0;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL async_dout got=%h exp=00", dout); end
      n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL async_stall got=%b exp=0", stall); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL async_done got=%b exp=0", done); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL async_err got=%b exp=0", err); end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_hold_done got=%b exp=0", done); end
      end
      rst_n = 1'b1;
      $display("reset during read released");
      mem_write = 1'b1;
      address = 8'h10;
      data_in = 8'h99;
      @(negedge clk);
      mem_write = 1'b0;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL abort_store_stall got=%b exp=0", stall); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_store_done got=%b exp=0", done); end
      $display("reset during write released");
      do_load(8'h10, d, sc);
      n_cmp++; if (d !== 8'h3C) begin n_fail++; $display("FAIL retained_data got=%h exp=3c", d); end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_err();
      test_back_to_back();
      test_ignore_inflight();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
